vec_mem_stage: RTL



---
 rtl/vec_mem_stage.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/vec_mem_stage.sv
// MEM pipeline stage: registers the EX bundle toward write-back and sequences multi-beat
// vector loads/stores over a req/ack data bus. Optional feature macro: MEM_STRIDE_EN.
module vec_mem_stage #(
  parameter int unsigned VL    = 8,
  parameter int unsigned SEW   = 32,
  parameter int unsigned BUS_W = 64
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_stall,
  input  logic                i_reg_write,
  input  logic                i_is_v,
  input  logic                i_is_s,
  input  logic [4:0]          i_rd,
  input  logic [4:0]          i_vd,
  input  logic [3:0]          i_sel,
  input  logic [1:0]          i_mem_op,
  input  logic [31:0]         i_rs1_addr,
`ifdef MEM_STRIDE_EN
  input  logic [31:0]         i_stride,
`endif
  input  logic [31:0]         i_result_s,
  input  logic [VL*SEW-1:0]   i_result_v,
  output logic                o_stall,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [31:0]         o_mem_addr,
  output logic [BUS_W-1:0]    o_mem_wdata,
  input  logic                i_mem_ack,
  input  logic [BUS_W-1:0]    i_mem_rdata,
  output logic                o_reg_write,
  output logic                o_is_v,
  output logic                o_is_s,
  output logic [4:0]          o_rd,
  output logic [4:0]          o_vd,
  output logic [3:0]          o_sel,
  output logic [31:0]         o_result_s,
  output logic [VL*SEW-1:0]   o_result_v
);

  localparam int unsigned VW    = VL * SEW;
  localparam int unsigned BEATS = VW / BUS_W;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LastBeat = CW'(BEATS - 1);

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_beat;
  logic              r_is_store;
  logic [VW-1:0]     r_sdata;
  logic [VW-1:0]     r_ldata;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [31:0]       r_mem_addr;
  logic [BUS_W-1:0]  r_mem_wdata;
  logic              r_reg_write;
  logic              r_is_v;
  logic              r_is_s;
  logic [4:0]        r_rd;
  logic [4:0]        r_vd;
  logic [3:0]        r_sel;
  logic [31:0]       r_result_s;
  logic [VW-1:0]     r_result_v;

  logic              w_start;
  logic              w_commit;
  logic              w_bubble;
  logic [31:0]       w_step;
  logic [VW-1:0]     w_ld_next;

  assign w_start  = i_is_v && ((i_mem_op == 2'b01) || (i_mem_op == 2'b10)) && !i_stall;
  assign w_commit = !i_stall && ((r_state == StDone) || ((r_state == StIdle) && !w_start));
  assign w_bubble = ((r_state == StIdle) && w_start) || ((r_state == StXfer) && !i_stall);
  assign o_stall  = ((r_state == StIdle) && w_start) || (r_state == StXfer);

`ifdef MEM_STRIDE_EN
  logic [31:0] r_step;
  assign w_step = r_step;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                          r_step <= '0;
    else if ((r_state == StIdle) && w_start) r_step <= i_stride;
  end
`else
  assign w_step = 32'(BUS_W / 8);
`endif

  // Load beats shift in from the top so beat 0 ends up in the lowest slice.
  if (BEATS > 1) begin : g_ld_shift
    assign w_ld_next = {i_mem_rdata, r_ldata[VW-1:BUS_W]};
  end else begin : g_ld_single
    assign w_ld_next = i_mem_rdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_beat      <= '0;
      r_is_store  <= 1'b0;
      r_sdata     <= '0;
      r_ldata     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            r_state     <= StXfer;
            r_beat      <= '0;
            r_is_store  <= (i_mem_op == 2'b10);
            r_mem_req   <= 1'b1;
            r_mem_we    <= (i_mem_op == 2'b10);
            r_mem_addr  <= i_rs1_addr;
            r_mem_wdata <= i_result_v[BUS_W-1:0];
            r_sdata     <= i_result_v >> BUS_W;
          end
        end
        StXfer: begin
          if (i_mem_ack) begin
            if (!r_is_store) r_ldata <= w_ld_next;
            if (r_beat == LastBeat) begin
              r_state   <= StDone;
              r_beat    <= '0;
              r_mem_req <= 1'b0;
              r_mem_we  <= 1'b0;
            end else begin
              r_beat      <= r_beat + CW'(1);
              r_mem_addr  <= r_mem_addr + w_step;
              r_mem_wdata <= r_sdata[BUS_W-1:0];
              r_sdata     <= r_sdata >> BUS_W;
            end
          end
        end
        StDone: begin
          if (!i_stall) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_reg_write <= 1'b0;
      r_is_v      <= 1'b0;
      r_is_s      <= 1'b0;
      r_rd        <= '0;
      r_vd        <= '0;
      r_sel       <= 4'hF;
      r_result_s  <= '0;
      r_result_v  <= '0;
    end else if (w_commit) begin
      r_reg_write <= i_reg_write;
      r_is_v      <= i_is_v;
      r_is_s      <= i_is_s;
      r_rd        <= i_rd;
      r_vd        <= i_vd;
      r_sel       <= i_sel;
      r_result_s  <= i_result_s;
      r_result_v  <= ((r_state == StDone) && !r_is_store) ? r_ldata : i_result_v;
    end else if (w_bubble) begin
      r_reg_write <= 1'b0;
      r_is_v      <= 1'b0;
      r_is_s      <= 1'b0;
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_reg_write = r_reg_write;
  assign o_is_v      = r_is_v;
  assign o_is_s      = r_is_s;
  assign o_rd        = r_rd;
  assign o_vd        = r_vd;
  assign o_sel       = r_sel;
  assign o_result_s  = r_result_s;
  assign o_result_v  = r_result_v;

endmodule
